gyro_bias_calib: RTL and testbench
==================================

GYRO_BIAS_CALIB -- requirements
Module: gyro_bias_calib

Interface
REQ-001 SHALL have parameter SAMPLE_LOG2, default 8, meaning log2 of the number of averaged samples (2^SAMPLE_LOG2).
REQ-002 SHALL have parameter SETTLE_NUM, default 16, meaning the number of leading samples discarded before accumulation.
REQ-003 SHALL have parameter MOTION_THRESH, default 16'd500, meaning the maximum allowed |sample - reference| per axis during accumulation.
REQ-004 clk_in  input  1  system clock; the only clock.
REQ-005 rst_in  input  1  reset; asynchronous, active-high.
REQ-006 gyro_x_raw_in  input  16  signed raw gyro X sample.
REQ-007 gyro_y_raw_in  input  16  signed raw gyro Y sample.
REQ-008 gyro_raw_vld_in  input  1  one-cycle strobe qualifying both raw samples.
REQ-009 calib_start_in  input  1  recalibration request; level or pulse.
REQ-010 gyro_x_bias_out  output  16  signed X bias, registered.
REQ-011 gyro_y_bias_out  output  16  signed Y bias, registered.
REQ-012 calib_done_pos_out  output  1  one-cycle pulse when new biases become valid.
REQ-013 calib_busy_out  output  1  high while in SETTLE, ACCUM or FINISH.

Function
REQ-014 FSM states SHALL be IDLE, SETTLE, ACCUM, FINISH; after reset release the FSM SHALL leave IDLE for SETTLE on the first clock edge.
REQ-015 SETTLE SHALL count accepted strobes; on the SETTLE_NUM-th strobe the FSM SHALL go to ACCUM, and that strobe's samples SHALL NOT be accumulated.
REQ-016 The first strobe in ACCUM SHALL load ref_x/ref_y and be accumulated as sample 1.
REQ-017 Accumulators SHALL be signed, 16+SAMPLE_LOG2 bits wide, and sign-extended on add; overflow SHALL be impossible by construction.
REQ-018 Motion check: if |x-ref_x| or |y-ref_y| (17-bit difference, no wrap) exceeds MOTION_THRESH on a strobe in ACCUM, the FSM SHALL clear the accumulators and sample counter and return to SETTLE; that sample SHALL be discarded.
REQ-019 When the 2^SAMPLE_LOG2-th sample is accepted at edge k, the FSM SHALL enter FINISH at k.
REQ-020 In FINISH, bias = (acc + 2^(SAMPLE_LOG2-1)) >>> SAMPLE_LOG2 (round half up, arithmetic shift); it SHALL be registered at edge k+1, with calib_done_pos_out high for exactly the cycle following k+1; the FSM SHALL then go to IDLE.
REQ-021 Bias outputs SHALL hold their last value in all other states, including during recalibration.
REQ-022 calib_start_in high in IDLE SHALL start SETTLE on the next edge; in any other state it SHALL be ignored (not queued).
REQ-023 Strobes arriving in IDLE or FINISH SHALL be ignored.
REQ-024 calib_busy_out SHALL be combinationally derived from the state register, glitch-free at edges.

Reset
REQ-025 On rst_in high, asynchronously: state=IDLE, counters=0, accumulators=0, refs=0, bias outputs=0, calib_done_pos_out=0, calib_busy_out=0.
REQ-026 Reset asserted mid-SETTLE/ACCUM/FINISH SHALL abort with no done pulse; calibration SHALL restart from SETTLE after release.

Structure
REQ-027 The state encoding and the default SAMPLE_LOG2/SETTLE_NUM/MOTION_THRESH SHALL live in a shared package, kalman_pkg, alongside the Kalman Q/DELTA_T constants.
REQ-028 One sub-module, gyro_axis_accum, SHALL be instantiated twice (X, Y); it SHALL contain the accumulator, reference, motion compare and rounding; the FSM and counters SHALL stay in the top.
REQ-029 The outputs SHALL connect directly to the Kalman iteration unit's bias and calib_done_pos inputs.

Verification (SAMPLE_LOG2=4, SETTLE_NUM=2, MOTION_THRESH=500)
REQ-030 Constant x=100, y=-37 strobes -> after 18 strobes, bias 100/-37 and a single done pulse 2 edges after the 18th strobe.
REQ-031 x alternating 0,1 (sum 8) and y alternating -3,-2 (sum -40) -> biases 1 and -2 (rounding check).
REQ-032 x=0 with 6th ACCUM sample x=1000 -> return to SETTLE, no pulse; done only after 2+16 further clean strobes.
REQ-033 rst_in pulse after the 10th ACCUM sample -> outputs 0 immediately, no pulse; full recalibration (18 strobes) after release.
REQ-034 calib_start_in during ACCUM -> ignored (exactly one pulse); calib_start_in in IDLE with x=-5 -> bias 5->-5 only at the new done pulse, old value held meanwhile.
REQ-035 Strobes at x=32767 and x=-32768 (threshold disabled via param 16'hFFFF) -> no accumulator overflow; biases 32767 / -32768.

Source files
------------

// File: rtl/kalman_pkg.sv
// Shared constants for the attitude filter: calibration FSM encoding,
// calibration defaults and Kalman tuning constants.
package kalman_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_ACCUM  = 2'd2;
    localparam logic [1:0] ST_FINISH = 2'd3;

    localparam int          CALIB_SAMPLE_LOG2   = 8;
    localparam int          CALIB_SETTLE_NUM    = 16;
    localparam logic [15:0] CALIB_MOTION_THRESH = 16'd500;

    localparam logic [15:0] KALMAN_Q_ANGLE = 16'd1;
    localparam logic [15:0] KALMAN_Q_BIAS  = 16'd3;
    localparam logic [15:0] KALMAN_DELTA_T = 16'd10;

    // 17-bit magnitude of a - b, so full-scale swings never wrap
    function automatic logic [16:0] abs_diff17(
        input logic signed [15:0] a,
        input logic signed [15:0] b
    );
        logic signed [16:0] d;
        d = 17'(a) - 17'(b);
        return d[16] ? 17'(-d) : 17'(d);
    endfunction

endpackage

// File: rtl/gyro_axis_accum.sv
// Per-axis bias datapath: reference sample, motion compare,
// sign-extended accumulator and round-half-up averaging.
module gyro_axis_accum
    import kalman_pkg::*;
#(
    parameter int          SAMPLE_LOG2   = CALIB_SAMPLE_LOG2,
    parameter logic [15:0] MOTION_THRESH = CALIB_MOTION_THRESH
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic signed [15:0] sample_in,
    input  logic               load_in,
    input  logic               add_in,
    input  logic               clear_in,
    input  logic               finish_in,
    output logic               motion_out,
    output logic signed [15:0] bias_out
);

    localparam int AW = 16 + SAMPLE_LOG2;
    localparam logic signed [AW-1:0] HALF = AW'(1 << (SAMPLE_LOG2 - 1));

    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] rnd;
    logic signed [AW-1:0] ext;
    logic signed [15:0]   ref_q;

    always_comb begin
        ext        = AW'(sample_in);
        motion_out = abs_diff17(sample_in, ref_q) > {1'b0, MOTION_THRESH};
        rnd        = (acc + HALF) >>> SAMPLE_LOG2;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            acc      <= '0;
            ref_q    <= '0;
            bias_out <= '0;
        end else begin
            if (clear_in) begin
                acc   <= '0;
                ref_q <= '0;
            end else if (add_in) begin
                acc <= (load_in ? '0 : acc) + ext;
                if (load_in)
                    ref_q <= sample_in;
            end
            if (finish_in)
                bias_out <= rnd[15:0];
        end
    end

endmodule

// File: rtl/gyro_bias_calib.sv
// Gyro bias calibration: settle, average 2^SAMPLE_LOG2 still samples,
// publish rounded X/Y biases with a one-cycle done pulse.
module gyro_bias_calib
    import kalman_pkg::*;
#(
    parameter int          SAMPLE_LOG2   = CALIB_SAMPLE_LOG2,
    parameter int          SETTLE_NUM    = CALIB_SETTLE_NUM,
    parameter logic [15:0] MOTION_THRESH = CALIB_MOTION_THRESH
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic signed [15:0] gyro_x_raw_in,
    input  logic signed [15:0] gyro_y_raw_in,
    input  logic               gyro_raw_vld_in,
    input  logic               calib_start_in,
    output logic signed [15:0] gyro_x_bias_out,
    output logic signed [15:0] gyro_y_bias_out,
    output logic               calib_done_pos_out,
    output logic               calib_busy_out
);

    localparam int CW = SAMPLE_LOG2 + 1;

    logic [1:0]    state;
    logic          boot;
    logic [15:0]   settle_cnt;
    logic [CW-1:0] smp_cnt;

    logic mot_x, mot_y;
    logic in_accum, first, motion, take, last, clr, fin;

    always_comb begin
        in_accum = (state == ST_ACCUM) && gyro_raw_vld_in;
        first    = (smp_cnt == '0);
        motion   = in_accum && !first && (mot_x || mot_y);
        take     = in_accum && !motion;
        last     = take && (smp_cnt == CW'(2 ** SAMPLE_LOG2 - 1));
        fin      = (state == ST_FINISH);
        clr      = motion || fin;
        calib_busy_out = (state != ST_IDLE);
    end

    // boot forces the first calibration right after reset release
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state              <= ST_IDLE;
            boot               <= 1'b1;
            settle_cnt         <= '0;
            smp_cnt            <= '0;
            calib_done_pos_out <= 1'b0;
        end else begin
            boot               <= 1'b0;
            calib_done_pos_out <= fin;
            unique case (state)
                ST_IDLE: begin
                    settle_cnt <= '0;
                    smp_cnt    <= '0;
                    if (boot || calib_start_in)
                        state <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (gyro_raw_vld_in) begin
                        if (settle_cnt == 16'(SETTLE_NUM - 1)) begin
                            settle_cnt <= '0;
                            state      <= ST_ACCUM;
                        end else begin
                            settle_cnt <= settle_cnt + 16'd1;
                        end
                    end
                end
                ST_ACCUM: begin
                    if (motion) begin
                        smp_cnt <= '0;
                        state   <= ST_SETTLE;
                    end else if (last) begin
                        smp_cnt <= '0;
                        state   <= ST_FINISH;
                    end else if (take) begin
                        smp_cnt <= smp_cnt + CW'(1);
                    end
                end
                ST_FINISH: state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    gyro_axis_accum #(
        .SAMPLE_LOG2  (SAMPLE_LOG2),
        .MOTION_THRESH(MOTION_THRESH)
    ) u_x (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .sample_in (gyro_x_raw_in),
        .load_in   (first),
        .add_in    (take),
        .clear_in  (clr),
        .finish_in (fin),
        .motion_out(mot_x),
        .bias_out  (gyro_x_bias_out)
    );

    gyro_axis_accum #(
        .SAMPLE_LOG2  (SAMPLE_LOG2),
        .MOTION_THRESH(MOTION_THRESH)
    ) u_y (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .sample_in (gyro_y_raw_in),
        .load_in   (first),
        .add_in    (take),
        .clear_in  (clr),
        .finish_in (fin),
        .motion_out(mot_y),
        .bias_out  (gyro_y_bias_out)
    );

endmodule

// File: tb/tb_gyro_bias_calib.sv
// Bench for gyro_bias_calib: directed scenarios plus randomized
// calibrations against a sample-list reference model.
module tb_gyro_bias_calib;

    localparam int L  = 4;
    localparam int SN = 2;
    localparam int MT = 500;
    localparam int N  = 1 << L;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic signed [15:0] gx = '0, gy = '0;
    logic vld = 1'b0, start = 1'b0;
    logic signed [15:0] bx, by;
    logic done, busy;

    logic signed [15:0] gx2 = '0, gy2 = '0;
    logic vld2 = 1'b0, start2 = 1'b0;
    logic signed [15:0] bx2, by2;
    logic done2, busy2;

    int checks = 0;
    int errors = 0;

    // reference model state
    bit m_active;
    int m_settle;
    int mx[$];
    int my[$];
    int m_bx, m_by;

    always #5 clk = ~clk;

    gyro_bias_calib #(
        .SAMPLE_LOG2(L), .SETTLE_NUM(SN), .MOTION_THRESH(16'(MT))
    ) dut (
        .clk_in(clk), .rst_in(rst),
        .gyro_x_raw_in(gx), .gyro_y_raw_in(gy),
        .gyro_raw_vld_in(vld), .calib_start_in(start),
        .gyro_x_bias_out(bx), .gyro_y_bias_out(by),
        .calib_done_pos_out(done), .calib_busy_out(busy)
    );

    gyro_bias_calib #(
        .SAMPLE_LOG2(L), .SETTLE_NUM(SN), .MOTION_THRESH(16'hFFFF)
    ) dut2 (
        .clk_in(clk), .rst_in(rst),
        .gyro_x_raw_in(gx2), .gyro_y_raw_in(gy2),
        .gyro_raw_vld_in(vld2), .calib_start_in(start2),
        .gyro_x_bias_out(bx2), .gyro_y_bias_out(by2),
        .calib_done_pos_out(done2), .calib_busy_out(busy2)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int iabs(input int v);
        return v < 0 ? -v : v;
    endfunction

    // floor((s + N/2) / N) with true floor for negatives
    function automatic int round_avg(input longint s);
        longint t, r;
        t = s + N / 2;
        r = ((t % N) + N) % N;
        return int'((t - r) / N);
    endfunction

    function automatic longint qsum(input int q[$]);
        longint s = 0;
        foreach (q[i]) s += q[i];
        return s;
    endfunction

    task automatic model_step(input int x, input int y, output bit fin);
        fin = 1'b0;
        if (!m_active) return;
        if (m_settle < SN) begin
            m_settle++;
            return;
        end
        if (mx.size() > 0 &&
            (iabs(x - mx[0]) > MT || iabs(y - my[0]) > MT)) begin
            mx.delete();
            my.delete();
            m_settle = 0;
            return;
        end
        mx.push_back(x);
        my.push_back(y);
        if (mx.size() == N) begin
            m_bx = round_avg(qsum(mx));
            m_by = round_avg(qsum(my));
            mx.delete();
            my.delete();
            m_active = 1'b0;
            fin = 1'b1;
        end
    endtask

    task automatic strobe(input int x, input int y);
        bit fin;
        @(negedge clk);
        gx  = 16'(x);
        gy  = 16'(y);
        vld = 1'b1;
        @(posedge clk);
        #1 vld = 1'b0;
        model_step(x, y, fin);
        chk("done_low_at_strobe", int'(done), 0);
        if (fin) begin
            @(posedge clk);
            #1;
            chk("done_pulse", int'(done), 1);
            chk("bias_x", int'(bx), m_bx);
            chk("bias_y", int'(by), m_by);
            @(posedge clk);
            #1;
            chk("done_single", int'(done), 0);
            chk("busy_after_done", int'(busy), 0);
        end else begin
            chk("bias_x_hold", int'(bx), m_bx);
            chk("bias_y_hold", int'(by), m_by);
            chk("busy_state", int'(busy), int'(m_active));
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        if (!m_active) begin
            m_active = 1'b1;
            m_settle = 0;
        end
        chk("busy_after_start", int'(busy), 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_bias_x", int'(bx), 0);
        chk("rst_bias_y", int'(by), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_busy", int'(busy), 0);
        m_active = 1'b1;
        m_settle = 0;
        mx.delete();
        my.delete();
        m_bx = 0;
        m_by = 0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("boot_busy", int'(busy), 1);
        chk("boot_done", int'(done), 0);
    endtask

    task automatic run2(input bit extreme);
        longint sx = 0, sy = 0;
        int x, y;
        for (int i = 0; i < SN + N; i++) begin
            x = extreme ? 32767 : int'($urandom_range(0, 65535)) - 32768;
            y = extreme ? -32768 : int'($urandom_range(0, 65535)) - 32768;
            @(negedge clk);
            gx2  = 16'(x);
            gy2  = 16'(y);
            vld2 = 1'b1;
            @(posedge clk);
            #1 vld2 = 1'b0;
            if (i >= SN) begin
                sx += x;
                sy += y;
            end
        end
        chk("wide_done_early", int'(done2), 0);
        @(posedge clk);
        #1;
        chk("wide_done", int'(done2), 1);
        chk("wide_bias_x", int'(bx2), round_avg(sx));
        chk("wide_bias_y", int'(by2), round_avg(sy));
        @(posedge clk);
        #1;
        chk("wide_done_single", int'(done2), 0);
    endtask

    initial begin
        int base_x, base_y;
        do_reset();

        // constant samples
        repeat (SN + N) strobe(100, -37);

        // rounding: x 0,1 and y -3,-2
        pulse_start();
        for (int i = 0; i < SN + N; i++)
            strobe(i % 2, (i % 2) ? -2 : -3);

        // motion on 6th accumulated sample, then clean run
        pulse_start();
        for (int i = 0; i < SN + 5; i++) strobe(0, 0);
        strobe(1000, 0);
        chk("motion_busy", int'(busy), 1);
        repeat (SN + N) strobe(0, 0);

        // reset mid-accumulation
        pulse_start();
        for (int i = 0; i < SN + 10; i++) strobe(50, 60);
        do_reset();
        for (int i = 0; i < SN + N; i++)
            strobe(int'($urandom_range(0, 200)) - 100,
                   int'($urandom_range(0, 200)) - 100);

        // start ignored mid-run, then hold of the old bias
        pulse_start();
        for (int i = 0; i < SN + 5; i++) strobe(5, 7);
        pulse_start();
        for (int i = 0; i < N - 5; i++) strobe(5, 7);
        pulse_start();
        repeat (SN + N) strobe(-5, -9);

        // randomized calibrations with occasional jolts
        for (int c = 0; c < 6; c++) begin
            pulse_start();
            base_x = int'($urandom_range(0, 20000)) - 10000;
            base_y = int'($urandom_range(0, 20000)) - 10000;
            while (m_active) begin
                if ($urandom_range(0, 29) == 0)
                    strobe(base_x + 700, base_y);
                else
                    strobe(base_x + int'($urandom_range(0, 500)) - 250,
                           base_y + int'($urandom_range(0, 500)) - 250);
            end
        end

        // full-scale samples with threshold disabled
        run2(1'b1);
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        #1 start2 = 1'b0;
        chk("wide_busy", int'(busy2), 1);
        run2(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
